// File: rtl/ob_cn_table_ctrl.sv
// Conditional-order table controller: allocates free entries to incoming stop orders
// and emits matured entries downstream in round-robin order, then deallocates them.
package ob_pkg;
  typedef struct packed {
    logic        buy;
    logic [14:0] px;
    logic [15:0] qty;
  } cmd_t;
endpackage

// Handshakes: a transfer happens on a cycle where valid & ready are both high at the
// rising edge; a valid, once raised, holds its payload until that transfer.
module ob_cn_table_ctrl #(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  input  ob_pkg::cmd_t            in_cmd,
  output logic                    in_rdy,
  input  logic [N-1:0]            ent_busy_r,
  input  logic [N-1:0]            ent_mtr_r,
  input  ob_pkg::cmd_t [N-1:0]    ent_cmd_r,
  output logic [N-1:0]            al_vld,
  output ob_pkg::cmd_t            al_cmd_r,
  output logic [N-1:0]            dl_vld,
  output logic                    out_vld,
  output ob_pkg::cmd_t            out_cmd,
  input  logic                    out_rdy,
  output logic [$clog2(N):0]      occ_cnt_r,
  output logic [1:0]              dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EMIT    = 2'd1,
    S_DEALLOC = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  ob_pkg::cmd_t    out_cmd_q, out_cmd_d;
  logic [N-1:0]    al_vld_q, al_vld_d;
  ob_pkg::cmd_t    al_cmd_q, al_cmd_d;
  logic [CW-1:0]   occ_q, occ_d;

  logic [N-1:0]    free;
  logic            al_found;
  logic            rr_hit;
  logic [PW-1:0]   rr_idx;
  logic [PW-1:0]   rr_try;

  // An entry whose allocation strobe is in flight is not yet busy but must not be reused.
  assign free   = ~ent_busy_r & ~al_vld_q;
  assign in_rdy = |free;

  always_comb begin
    al_vld_d = '0;
    al_cmd_d = al_cmd_q;
    al_found = 1'b0;
    if (in_vld && in_rdy) begin
      al_cmd_d = in_cmd;
      for (int i = 0; i < N; i++) begin
        if (free[i] && !al_found) begin
          al_vld_d[i] = 1'b1;
          al_found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N; i++) begin
      occ_d = occ_d + CW'(ent_busy_r[i]);
    end
  end

  // Round-robin search over matured entries, starting at rr_ptr_q and wrapping.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = rr_ptr_q;
    rr_try = '0;
    for (int k = 0; k < N; k++) begin
      rr_try = PW'((int'(rr_ptr_q) + k) % N);
      if (!rr_hit && ent_mtr_r[rr_try]) begin
        rr_hit = 1'b1;
        rr_idx = rr_try;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
      out_cmd_q <= '0;
      al_vld_q  <= '0;
      al_cmd_q  <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      out_cmd_q <= out_cmd_d;
      al_vld_q  <= al_vld_d;
      al_cmd_q  <= al_cmd_d;
      occ_q     <= occ_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    out_cmd_d = out_cmd_q;
    case (state_q)
      S_IDLE: begin
        if (rr_hit) begin
          sel_d     = rr_idx;
          out_cmd_d = ent_cmd_r[rr_idx];
          state_d   = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_rdy) begin
          state_d  = S_DEALLOC;
          rr_ptr_d = (sel_q == PW'(N - 1)) ? '0 : sel_q + PW'(1);
        end
      end
      S_DEALLOC: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them immediately.
  always_comb begin
    out_vld = (state_q == S_EMIT);
    dl_vld  = '0;
    if (state_q == S_DEALLOC) dl_vld[sel_q] = 1'b1;
  end

  assign al_vld    = al_vld_q;
  assign al_cmd_r  = al_cmd_q;
  assign out_cmd   = out_cmd_q;
  assign occ_cnt_r = occ_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ob_cn_table_ctrl.sv
// Bench for ob_cn_table_ctrl: an entry-table environment plus a transaction-level model
// predicting allocation, occupancy and round-robin emission every cycle.
module tb_ob_cn_table_ctrl;
  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_vld;
  ob_pkg::cmd_t         in_cmd;
  logic                 in_rdy;
  logic [N-1:0]         ent_busy_r;
  logic [N-1:0]         ent_mtr_r;
  ob_pkg::cmd_t [N-1:0] ent_cmd_r;
  logic [N-1:0]         al_vld;
  ob_pkg::cmd_t         al_cmd_r;
  logic [N-1:0]         dl_vld;
  logic                 out_vld;
  ob_pkg::cmd_t         out_cmd;
  logic                 out_rdy;
  logic [$clog2(N):0]   occ_cnt_r;
  logic [1:0]           dbg_state;

  ob_cn_table_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy),
    .ent_busy_r(ent_busy_r), .ent_mtr_r(ent_mtr_r), .ent_cmd_r(ent_cmd_r),
    .al_vld(al_vld), .al_cmd_r(al_cmd_r), .dl_vld(dl_vld),
    .out_vld(out_vld), .out_cmd(out_cmd), .out_rdy(out_rdy),
    .occ_cnt_r(occ_cnt_r), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: entry table contents and the emit/retire bookkeeping.
  logic [N-1:0] m_busy, m_mtr, m_al;
  ob_pkg::cmd_t m_cmd [N];
  ob_pkg::cmd_t m_alcmd, m_outcmd;
  int           m_occ, m_sel, m_rr;
  bit           m_emit, m_retire;
  logic [N-1:0] dl_seen[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = '0; m_mtr = '0; m_al = '0;
    for (int i = 0; i < N; i++) m_cmd[i] = '0;
    m_alcmd = '0; m_outcmd = '0;
    m_occ = 0; m_sel = 0; m_rr = 0;
    m_emit = 0; m_retire = 0;
  endtask

  task automatic apply_entries();
    ent_busy_r = m_busy;
    ent_mtr_r  = m_mtr;
    for (int i = 0; i < N; i++) ent_cmd_r[i] = m_cmd[i];
  endtask

  // One clock: check outputs at negedge, drive inputs, advance model, update entries after the edge.
  task automatic cycle(input int p_vld, input int p_mat, input int p_rdy);
    logic [N-1:0] fr, e_dl, nb, nm, nal;
    logic e_rdy, e_ov;
    bit found;
    int j;
    @(negedge clk);
    fr    = ~m_busy & ~m_al;
    e_rdy = |fr;
    e_ov  = m_emit && !m_retire;
    e_dl  = '0;
    if (m_retire) e_dl[m_sel] = 1'b1;
    chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
    chk("al_vld", 64'(al_vld), 64'(m_al));
    if (m_al != '0) chk("al_cmd", 64'(al_cmd_r), 64'(m_alcmd));
    chk("occ_cnt", 64'(occ_cnt_r), 64'(m_occ));
    chk("out_vld", 64'(out_vld), 64'(e_ov));
    if (e_ov) chk("out_cmd", 64'(out_cmd), 64'(m_outcmd));
    chk("dl_vld", 64'(dl_vld), 64'(e_dl));
    if (dl_vld != '0) dl_seen.push_back(dl_vld);

    in_vld  = (int'($urandom_range(99)) < p_vld);
    in_cmd  = ob_pkg::cmd_t'($urandom);
    out_rdy = (int'($urandom_range(99)) < p_rdy);

    // Emission: one order in flight; after retire the table must be re-sampled.
    if (m_retire) begin
      m_retire = 0;
      m_emit   = 0;
    end else if (m_emit) begin
      if (out_rdy) begin
        m_retire = 1;
        m_rr     = (m_sel + 1) % N;
      end
    end else if (m_mtr != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!found && m_mtr[j]) begin
          found    = 1;
          m_sel    = j;
          m_outcmd = m_cmd[j];
        end
      end
      m_emit = 1;
    end

    nb = m_busy;
    nm = m_mtr;
    for (int i = 0; i < N; i++) begin
      if (m_al[i]) begin
        nb[i]    = 1'b1;
        nm[i]    = 1'b0;
        m_cmd[i] = m_alcmd;
      end else if (e_dl[i]) begin
        nb[i] = 1'b0;
        nm[i] = 1'b0;
      end else if (m_busy[i] && !m_mtr[i] && int'($urandom_range(99)) < p_mat) begin
        nm[i] = 1'b1;
      end
    end

    nal   = '0;
    found = 0;
    if (in_vld && e_rdy) begin
      m_alcmd = in_cmd;
      for (int i = 0; i < N; i++) begin
        if (fr[i] && !found) begin
          nal[i] = 1'b1;
          found  = 1;
        end
      end
    end

    m_occ  = $countones(m_busy);
    m_busy = nb;
    m_mtr  = nm;
    m_al   = nal;
    @(posedge clk);
    #1;
    apply_entries();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_vld = 1'b0; in_cmd = '0; out_rdy = 1'b0;
    model_clear();
    apply_entries();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_al_vld", 64'(al_vld), 64'd0);
    chk("rst_dl_vld", 64'(dl_vld), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_cmd", 64'(out_cmd), 64'd0);
    chk("rst_al_cmd", 64'(al_cmd_r), 64'd0);
    chk("rst_occ", 64'(occ_cnt_r), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    rst = 1'b1;

    // Three back-to-back allocations into an empty table, no maturation.
    for (int c = 0; c < 3; c++) cycle(100, 0, 0);
    for (int c = 0; c < 3; c++) cycle(0, 0, 0);
    // Mature entries 1 and 2 with the pointer at zero: expect 1 then 2.
    dl_seen.delete();
    m_mtr = 4'b0110;
    apply_entries();
    for (int c = 0; c < 10; c++) cycle(0, 0, 100);
    chk("rr_dl_count", 64'(dl_seen.size()), 64'd2);
    if (dl_seen.size() >= 2) begin
      chk("rr_dl_first", 64'(dl_seen[0]), 64'(4'b0010));
      chk("rr_dl_second", 64'(dl_seen[1]), 64'(4'b0100));
    end

    // Fill the table and keep offering: nothing may be accepted while full.
    for (int c = 0; c < 10; c++) cycle(100, 0, 0);
    chk("full_busy", 64'(ent_busy_r), 64'hf);
    // Mature everything while downstream stalls, then release randomly.
    for (int c = 0; c < 8; c++) cycle(100, 100, 0);
    for (int c = 0; c < 1500; c++) cycle(50, 30, 60);

    // Reset in the middle of an emission.
    begin
      int budget = 0;
      while (!(m_emit && !m_retire) && budget < 40) begin
        cycle(100, 100, 0);
        budget++;
      end
      chk("emit_reached", 64'(m_emit && !m_retire), 64'd1);
    end
    @(negedge clk);
    chk("pre_rst_out_vld", 64'(out_vld), 64'(m_emit && !m_retire));
    in_vld = 1'b0; out_rdy = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_dl_vld", 64'(dl_vld), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_occ", 64'(occ_cnt_r), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_dl_hold", 64'(dl_vld), 64'd0);
    model_clear();
    apply_entries();
    rst = 1'b1;

    for (int c = 0; c < 1000; c++) cycle(40, 25, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ob_cn_table_ctrl.md
OB_CN_TABLE_CTRL -- requirements
Module: ob_cn_table_ctrl

Interface
REQ-001 SHALL have parameter N, 4, number of conditional-table entries managed (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_vld  input  1  new stop order offered.
REQ-005 SHALL have port in_cmd  input  ob_pkg::cmd_t  offered order.
REQ-006 SHALL have port in_rdy  output  1  order accepted when in_vld & in_rdy.
REQ-007 SHALL have port ent_busy_r  input  N  per-entry busy state.
REQ-008 SHALL have port ent_mtr_r  input  N  per-entry matured state.
REQ-009 SHALL have port ent_cmd_r  input  N x ob_pkg::cmd_t  per-entry latched command.
REQ-010 SHALL have port al_vld  output  N  one-hot allocation strobe to entries.
REQ-011 SHALL have port al_cmd_r  output  ob_pkg::cmd_t  command driven with al_vld.
REQ-012 SHALL have port dl_vld  output  N  one-hot deallocation strobe to entries.
REQ-013 SHALL have port out_vld  output  1  matured order presented downstream.
REQ-014 SHALL have port out_cmd  output  ob_pkg::cmd_t  matured order payload.
REQ-015 SHALL have port out_rdy  input  1  downstream accepts when out_vld & out_rdy.
REQ-016 SHALL have port occ_cnt_r  output  clog2(N)+1  number of busy entries, registered.

Function
REQ-017 SHALL compute free mask = ~ent_busy_r & ~al_vld (entry being allocated this cycle is not free).
REQ-018 SHALL drive in_rdy = (free mask != 0), combinational.
REQ-019 SHALL, on in_vld & in_rdy, register al_vld next cycle as one-hot of lowest-index free entry and al_cmd_r = in_cmd; al_vld is a single-cycle pulse.
REQ-020 SHALL ignore in_vld while in_rdy low (no state change, no al_vld).
REQ-021 SHALL run emit FSM with states IDLE, EMIT, DEALLOC.
REQ-022 IDLE: if ent_mtr_r != 0, select matured entry round-robin starting at pointer rr_ptr; latch index sel and out_cmd = ent_cmd_r[sel]; go EMIT.
REQ-023 EMIT: out_vld = 1; out_cmd held stable; on out_rdy go DEALLOC and set rr_ptr = (sel+1) mod N.
REQ-024 DEALLOC: dl_vld = one-hot(sel) for exactly one cycle; go IDLE unconditionally.
REQ-025 SHALL not reselect an entry in the cycle after DEALLOC (entry mtr drops at that edge; IDLE samples next cycle).
REQ-026 out_vld latency: asserted the cycle after first ent_mtr_r bit observed in IDLE; minimum 3 cycles per emitted order at out_rdy=1.
REQ-027 SHALL allow allocation and deallocation in the same cycle on different entries independently.
REQ-028 SHALL keep occ_cnt_r = popcount(ent_busy_r) registered one cycle; never exceeds N.
REQ-029 out_vld SHALL not deassert without out_rdy handshake.

Reset
REQ-030 On rst low: al_vld=0, dl_vld=0, out_vld=0, out_cmd=0, al_cmd_r=0, occ_cnt_r=0, rr_ptr=0, FSM=IDLE; in_rdy follows REQ-018.
REQ-031 Reset mid-EMIT SHALL drop out_vld immediately with no dl_vld issued.

Verification
REQ-032 Empty table, in_vld one cycle -> al_vld=4'b0001 next cycle with al_cmd_r=in_cmd; occ_cnt_r=1 two cycles later.
REQ-033 ent_busy_r=4'b1111 -> in_rdy=0, in_vld held 5 cycles produces no al_vld.
REQ-034 ent_mtr_r=4'b0110, rr_ptr=0, out_rdy=1 -> emits entry 1 then entry 2; dl_vld=0010 then 0100.
REQ-035 out_rdy low 4 cycles in EMIT -> out_vld and out_cmd stable, no dl_vld until handshake.
REQ-036 Back-to-back in_vld on two cycles with entries 0,1 free -> al_vld=0001 then 0010, never same entry twice.
REQ-037 rst asserted during EMIT -> out_vld=0 same cycle; after release FSM IDLE, rr_ptr=0.
